// File: rtl/window_scanner.sv
// -----------------------------------------------------------------------------
// window_scanner
//
// Walks a square detection window over a scaled image in raster order.
// Each accepted command describes one scale of a frame. The scanner emits
// one window top-left position per downstream handshake and flags the final
// window of the frame with window_pos_eot. A scale smaller than the window
// produces no positions. frame_done pulses once when the frame completes.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   cmd_valid/ready     scale command handshake (ready only while idle)
//   cmd_scale           scale index, passed through to window_pos_scale
//   cmd_width/height    scaled image size, 1..IMG_WIDTH / 1..IMG_HEIGHT
//   cmd_last            this scale is the last one of the frame
//   window_pos_valid    a window position is offered
//   window_pos_ready    downstream accepts the position
//   window_pos_eot      offered window is the last one of the frame
//   window_pos_scale    scale index of the offered window
//   window_pos_x/y      top-left corner of the offered window
//   frame_done          one-cycle pulse after the frame's final window
// -----------------------------------------------------------------------------
module window_scanner #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int WIN_SIZE   = 24,
  parameter int STEP       = 1,
  localparam int W_X = $clog2(IMG_WIDTH),
  localparam int W_Y = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [7:0]     cmd_scale,
  input  logic [W_X:0]   cmd_width,
  input  logic [W_Y:0]   cmd_height,
  input  logic           cmd_last,
  output logic           window_pos_valid,
  input  logic           window_pos_ready,
  output logic           window_pos_eot,
  output logic [7:0]     window_pos_scale,
  output logic [W_X-1:0] window_pos_x,
  output logic [W_Y-1:0] window_pos_y,
  output logic           frame_done
);

  // Constants sized to the compare widths so all arithmetic is unsigned
  // at W_X+1 / W_Y+1 bits.
  localparam logic [W_X:0] WIN_X  = (W_X+1)'(WIN_SIZE);
  localparam logic [W_Y:0] WIN_Y  = (W_Y+1)'(WIN_SIZE);
  localparam logic [W_X:0] STEP_X = (W_X+1)'(STEP);
  localparam logic [W_Y:0] STEP_Y = (W_Y+1)'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  logic [7:0]     scale_reg;
  logic           last_reg;
  logic [W_X:0]   x_max_reg;
  logic [W_Y:0]   y_max_reg;
  logic [W_X-1:0] x_reg;
  logic [W_Y-1:0] y_reg;
  logic           frame_done_reg;
  logic           frame_done_next;

  logic           fits;
  logic           accept;
  logic           beat;
  logic [W_X:0]   x_step;
  logic [W_Y:0]   y_step;
  logic           row_last;
  logic           col_last;
  logic           scale_last;

  // A scale produces windows only if the window fits in both dimensions.
  assign fits = (cmd_width >= WIN_X) && (cmd_height >= WIN_Y);

  // The next position never exceeds the image size, so it fits in W+1 bits.
  assign x_step     = {1'b0, x_reg} + STEP_X;
  assign y_step     = {1'b0, y_reg} + STEP_Y;
  assign row_last   = x_step > x_max_reg;
  assign col_last   = y_step > y_max_reg;
  assign scale_last = row_last && col_last;

  assign accept = cmd_valid && cmd_ready;
  assign beat   = window_pos_valid && window_pos_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next       = state_reg;
    cmd_ready        = 1'b0;
    window_pos_valid = 1'b0;
    window_pos_eot   = 1'b0;
    frame_done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (fits) begin
            state_next = SCAN;
          end else begin
            // Empty scale: nothing to emit, but it may still close the frame.
            frame_done_next = cmd_last;
          end
        end
      end
      SCAN: begin
        window_pos_valid = 1'b1;
        window_pos_eot   = last_reg && scale_last;
        if (window_pos_ready && scale_last) begin
          state_next      = IDLE;
          frame_done_next = last_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scale parameters and raster position. Position only moves on a
  // transfer, which keeps the outputs stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scale_reg      <= '0;
      last_reg       <= 1'b0;
      x_max_reg      <= '0;
      y_max_reg      <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_done_next;
      if (accept && fits) begin
        scale_reg <= cmd_scale;
        last_reg  <= cmd_last;
        x_max_reg <= cmd_width - WIN_X;
        y_max_reg <= cmd_height - WIN_Y;
        x_reg     <= '0;
        y_reg     <= '0;
      end else if (beat) begin
        if (!row_last) begin
          x_reg <= x_step[W_X-1:0];
        end else if (!col_last) begin
          x_reg <= '0;
          y_reg <= y_step[W_Y-1:0];
        end else begin
          // Scale finished: park the position at the origin while idle.
          x_reg <= '0;
          y_reg <= '0;
        end
      end
    end
  end

  assign window_pos_scale = scale_reg;
  assign window_pos_x     = x_reg;
  assign window_pos_y     = y_reg;
  assign frame_done       = frame_done_reg;

endmodule

// File: tb/tb_window_scanner.sv
// -----------------------------------------------------------------------------
// tb_window_scanner
//
// Two scanners share clock and reset: instance 0 uses STEP=1, instance 1
// uses STEP=4. Each issued command expands, through a nested-loop reference
// model, into the expected sequence of window beats (and a frame_done marker
// when the scale closes the frame), pushed into a per-instance queue. A
// monitor on the falling edge pops and compares whenever a beat transfers or
// frame_done is high, and also checks hold-under-stall and idle outputs.
// -----------------------------------------------------------------------------
module tb_window_scanner;

  localparam int IW  = 45;
  localparam int IH  = 45;
  localparam int WIN = 24;
  localparam int WX  = $clog2(IW);
  localparam int WY  = $clog2(IH);

  typedef struct {
    bit done;
    int x;
    int y;
    int scale;
    bit eot;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;
  int beats [2];
  bit stalled [2];
  int sv_x [2];
  int sv_y [2];
  int sv_s [2];
  int sv_e [2];
  bit rand_ready = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cmd_valid;
  logic [1:0]    cmd_ready;
  logic [1:0]    cmd_last;
  logic [1:0]    pos_valid;
  logic [1:0]    pos_ready;
  logic [1:0]    pos_eot;
  logic [1:0]    frame_done;
  logic [7:0]    cmd_scale  [2];
  logic [WX:0]   cmd_width  [2];
  logic [WY:0]   cmd_height [2];
  logic [7:0]    pos_scale  [2];
  logic [WX-1:0] pos_x      [2];
  logic [WY-1:0] pos_y      [2];

  always #5 clk = ~clk;

  window_scanner #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_SIZE(WIN), .STEP(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_scale(cmd_scale[0]),
    .cmd_width(cmd_width[0]), .cmd_height(cmd_height[0]), .cmd_last(cmd_last[0]),
    .window_pos_valid(pos_valid[0]), .window_pos_ready(pos_ready[0]),
    .window_pos_eot(pos_eot[0]), .window_pos_scale(pos_scale[0]),
    .window_pos_x(pos_x[0]), .window_pos_y(pos_y[0]), .frame_done(frame_done[0])
  );

  window_scanner #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_SIZE(WIN), .STEP(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_scale(cmd_scale[1]),
    .cmd_width(cmd_width[1]), .cmd_height(cmd_height[1]), .cmd_last(cmd_last[1]),
    .window_pos_valid(pos_valid[1]), .window_pos_ready(pos_ready[1]),
    .window_pos_eot(pos_eot[1]), .window_pos_scale(pos_scale[1]),
    .window_pos_x(pos_x[1]), .window_pos_y(pos_y[1]), .frame_done(frame_done[1])
  );

  task automatic check(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int k, input int info);
    total++;
    bad++;
    $display("FAIL %s dut%0d: info=%0d at t=%0t", name, k, info, $time);
  endtask

  // Reference model: enumerate the raster directly from the scan rules.
  task automatic model(input int k, input int scale, input int w, input int h, input bit last);
    exp_t tmp[$];
    exp_t e;
    int   step;
    step = (k == 0) ? 1 : 4;
    if (w >= WIN && h >= WIN) begin
      for (int yy = 0; yy <= h - WIN; yy += step) begin
        for (int xx = 0; xx <= w - WIN; xx += step) begin
          e.done = 1'b0; e.x = xx; e.y = yy; e.scale = scale; e.eot = 1'b0;
          tmp.push_back(e);
        end
      end
      if (last) tmp[tmp.size()-1].eot = 1'b1;
    end
    if (last) begin
      e.done = 1'b1; e.x = 0; e.y = 0; e.scale = 0; e.eot = 1'b0;
      tmp.push_back(e);
    end
    foreach (tmp[i]) begin
      if (k == 0) q0.push_back(tmp[i]);
      else        q1.push_back(tmp[i]);
    end
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e.done = 1'b0; e.x = 0; e.y = 0; e.scale = 0; e.eot = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    bit   ok;
    check("cmd_ready_vs_valid", k, int'(cmd_ready[k]), int'(!pos_valid[k]));
    if (!pos_valid[k]) check("eot_when_idle", k, int'(pos_eot[k]), 0);
    if (stalled[k]) begin
      check("stall_valid", k, int'(pos_valid[k]), 1);
      check("stall_x", k, int'(pos_x[k]), sv_x[k]);
      check("stall_y", k, int'(pos_y[k]), sv_y[k]);
      check("stall_scale", k, int'(pos_scale[k]), sv_s[k]);
      check("stall_eot", k, int'(pos_eot[k]), sv_e[k]);
    end
    stalled[k] = pos_valid[k] && !pos_ready[k];
    sv_x[k] = int'(pos_x[k]);
    sv_y[k] = int'(pos_y[k]);
    sv_s[k] = int'(pos_scale[k]);
    sv_e[k] = int'(pos_eot[k]);
    if (frame_done[k]) begin
      pop_exp(k, e, ok);
      if (!ok) fail_now("unexpected_frame_done", k, 0);
      else     check("frame_done_order", k, int'(e.done), 1);
    end
    if (pos_valid[k] && pos_ready[k]) begin
      pop_exp(k, e, ok);
      beats[k]++;
      if (!ok) begin
        fail_now("unexpected_beat", k, int'(pos_x[k]) * 100 + int'(pos_y[k]));
      end else begin
        check("beat_not_done", k, int'(e.done), 0);
        check("beat_x", k, int'(pos_x[k]), e.x);
        check("beat_y", k, int'(pos_y[k]), e.y);
        check("beat_scale", k, int'(pos_scale[k]), e.scale);
        check("beat_eot", k, int'(pos_eot[k]), int'(e.eot));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  // Downstream ready: always 1, or random per cycle when backpressure is on.
  initial begin
    pos_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      pos_ready = rand_ready ? 2'($urandom) : 2'b11;
    end
  end

  task automatic send_cmd(input int k, input int scale, input int w, input int h, input bit last);
    bit acc;
    int n;
    model(k, scale, w, h, last);
    cmd_scale[k]  = 8'(scale);
    cmd_width[k]  = (WX+1)'(w);
    cmd_height[k] = (WY+1)'(h);
    cmd_last[k]   = last;
    cmd_valid[k]  = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = cmd_ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid[k] = 1'b0;
    if (!acc) fail_now("cmd_accept_timeout", k, n);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() > 0) fail_now("drain_timeout_left", 0, q0.size());
    if (q1.size() > 0) fail_now("drain_timeout_left", 1, q1.size());
    q0.delete();
    q1.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    int w;
    int h;
    cmd_valid = '0;
    cmd_last  = '0;
    for (int k = 0; k < 2; k++) begin
      cmd_scale[k] = '0; cmd_width[k] = '0; cmd_height[k] = '0;
      beats[k] = 0; stalled[k] = 1'b0;
    end

    // Reset state
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", k, int'(pos_valid[k]), 0);
      check("rst_eot", k, int'(pos_eot[k]), 0);
      check("rst_x", k, int'(pos_x[k]), 0);
      check("rst_y", k, int'(pos_y[k]), 0);
      check("rst_scale", k, int'(pos_scale[k]), 0);
      check("rst_frame_done", k, int'(frame_done[k]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", 0, int'(cmd_ready[0]), 1);
    check("cmd_ready_after_reset", 1, int'(cmd_ready[1]), 1);
    @(posedge clk);
    #1;

    // Single window, closes the frame
    send_cmd(0, 3, 24, 24, 1'b1);
    drain();
    // 3x2 raster, no frame end
    send_cmd(0, 7, 26, 25, 1'b0);
    drain();
    // STEP=4 over full image: 6x6 grid
    send_cmd(1, 9, 45, 45, 1'b1);
    drain();
    // Empty scales with and without frame end
    send_cmd(0, 5, 20, 45, 1'b1);
    send_cmd(1, 6, 45, 23, 1'b1);
    send_cmd(0, 8, 10, 10, 1'b0);
    drain();

    // Backpressure: 30x30 gives 7x7 on STEP=1, 2x2 on STEP=4
    rand_ready = 1'b1;
    b = beats[0];
    send_cmd(0, 11, 30, 30, 1'b1);
    send_cmd(1, 12, 30, 30, 1'b0);
    drain();
    check("beats_30x30", 0, beats[0] - b, 49);

    // Random back-to-back scales under random backpressure
    for (int i = 0; i < 14; i++) begin
      w = $urandom_range(18, IW);
      h = $urandom_range(18, IH);
      send_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), w, h, 1'($urandom));
    end
    drain();

    // Reset in the middle of a scan abandons it
    rand_ready = 1'b0;
    b = beats[0];
    send_cmd(0, 2, 45, 45, 1'b1);
    n = 0;
    while (beats[0] < b + 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (beats[0] < b + 5) fail_now("reset_wait_timeout", 0, beats[0] - b);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midscan_rst_valid", 0, int'(pos_valid[0]), 0);
    check("midscan_rst_eot", 0, int'(pos_eot[0]), 0);
    check("midscan_rst_x", 0, int'(pos_x[0]), 0);
    check("midscan_rst_y", 0, int'(pos_y[0]), 0);
    check("midscan_rst_scale", 0, int'(pos_scale[0]), 0);
    check("midscan_rst_frame_done", 0, int'(frame_done[0]), 0);
    q0.delete();
    q1.delete();
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    send_cmd(0, 4, 26, 25, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
